// File: rtl/register_file_param_if.sv
// Register file access bundle: two read ports, one byte-masked write port,
// a debug read port and the init status flag.
interface register_file_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0]   rd_addr_1;
    logic [ADDR_W-1:0]   rd_addr_2;
    logic                rd_en;
    logic [DATA_W-1:0]   rd_data_1;
    logic [DATA_W-1:0]   rd_data_2;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W/8-1:0] wr_be;
    logic [ADDR_W-1:0]   dbg_addr;
    logic [DATA_W-1:0]   dbg_data;
    logic                init_busy;

    modport master (
        output rd_addr_1, rd_addr_2, rd_en,
        output wr_en, wr_addr, wr_data, wr_be,
        output dbg_addr,
        input  rd_data_1, rd_data_2, dbg_data, init_busy
    );

    modport slave (
        input  rd_addr_1, rd_addr_2, rd_en,
        input  wr_en, wr_addr, wr_data, wr_be,
        input  dbg_addr,
        output rd_data_1, rd_data_2, dbg_data, init_busy
    );
endinterface

// File: rtl/register_file_param.sv
// Parameterised register file with byte-masked writes, write-to-read bypass,
// optional hard-wired zero entry and a post-reset init sequencer.
module register_file_param #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int ZERO_REG  = 1,
    parameter int INIT_MODE = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    register_file_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam bit ZR    = (ZERO_REG != 0);

    typedef enum logic {INIT, RUN} state_t;

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   init_ptr;
    logic [ADDR_W-1:0]   init_ptr_nx;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [NB-1:0]       we_be;
    logic [ADDR_W-1:0]   wa;
    logic [DATA_W-1:0]   wd;
    logic [DATA_W-1:0]   rd_1_nx;
    logic [DATA_W-1:0]   rd_2_nx;
    logic [DATA_W-1:0]   dbg_nx;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZR && (a == '0);
    endfunction

    assign bus.init_busy = (state == INIT);

    // State and init pointer register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= INIT;
            init_ptr <= '0;
        end else begin
            state    <= state_nx;
            init_ptr <= init_ptr_nx;
        end
    end

    // Next state and array write port selection (init fill vs. user write)
    always_comb begin
        state_nx    = state;
        init_ptr_nx = init_ptr;
        we_be       = '0;
        wa          = bus.wr_addr;
        wd          = bus.wr_data;
        unique case (state)
            INIT: begin
                we_be = '1;
                wa    = init_ptr;
                wd    = (INIT_MODE != 0) ? DATA_W'(init_ptr) : '0;
                if (&init_ptr) begin
                    state_nx = RUN;
                end else begin
                    init_ptr_nx = init_ptr + ADDR_W'(1);
                end
            end
            RUN: begin
                if (bus.wr_en && !is_zero(bus.wr_addr)) begin
                    we_be = bus.wr_be;
                end
            end
            default: ;
        endcase
    end

    // Storage array; contents survive reset, writes in the reset cycle drop
    always_ff @(posedge clock) begin
        if (reset_n) begin
            for (int b = 0; b < NB; b++) begin
                if (we_be[b]) begin
                    mem[wa][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end
    end

    // Read data with same-cycle write bypass merged per byte
    always_comb begin
        rd_1_nx = mem[bus.rd_addr_1];
        rd_2_nx = mem[bus.rd_addr_2];
        dbg_nx  = mem[bus.dbg_addr];
        for (int b = 0; b < NB; b++) begin
            if (bus.wr_en && bus.wr_be[b]) begin
                if (bus.wr_addr == bus.rd_addr_1) begin
                    rd_1_nx[8*b +: 8] = bus.wr_data[8*b +: 8];
                end
                if (bus.wr_addr == bus.rd_addr_2) begin
                    rd_2_nx[8*b +: 8] = bus.wr_data[8*b +: 8];
                end
            end
        end
        if (is_zero(bus.rd_addr_1)) rd_1_nx = '0;
        if (is_zero(bus.rd_addr_2)) rd_2_nx = '0;
        if (is_zero(bus.dbg_addr))  dbg_nx  = '0;
    end

    // Registered read and debug outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bus.rd_data_1 <= '0;
            bus.rd_data_2 <= '0;
            bus.dbg_data  <= '0;
        end else begin
            bus.dbg_data <= dbg_nx;
            if (state == INIT) begin
                bus.rd_data_1 <= '0;
                bus.rd_data_2 <= '0;
            end else if (bus.rd_en) begin
                bus.rd_data_1 <= rd_1_nx;
                bus.rd_data_2 <= rd_2_nx;
            end
        end
    end
endmodule

// File: tb/tb_register_file_param.sv
// Randomised self-checking bench for register_file_param: default build plus
// a 16-bit / 8-entry build with zero-fill init and no zero entry.
module tb_register_file_param;
    logic clk = 1'b0;
    logic rst_n;
    logic rst_n_s;

    always #5 clk = ~clk;

    register_file_param_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    register_file_param_if #(.DATA_W(16), .ADDR_W(3)) bus_s ();

    register_file_param dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    register_file_param #(
        .DATA_W    (16),
        .ADDR_W    (3),
        .ZERO_REG  (0),
        .INIT_MODE (0)
    ) dut_s (
        .clock   (clk),
        .reset_n (rst_n_s),
        .bus     (bus_s.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // ---------------- reference model, default build ----------------
    logic [31:0] rm [32];
    bit          known [32];
    int          init_left;
    logic [31:0] e1, e2, ed;
    bit          ed_ok;

    function automatic logic [31:0] rd_ref(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (bus.wr_en && bus.wr_addr == a)
            return merge(rm[a], bus.wr_data, bus.wr_be);
        return rm[a];
    endfunction

    task automatic tick(input string tag);
        logic [31:0] d;
        bit          dk;
        int          idx;
        if (!rst_n) begin
            init_left = 32;
            e1 = 0;
            e2 = 0;
            ed = 0;
            ed_ok = 1;
        end else begin
            dk = (bus.dbg_addr == 0) || known[bus.dbg_addr];
            d  = (bus.dbg_addr == 0) ? 32'h0 : rm[bus.dbg_addr];
            if (init_left > 0) begin
                idx = 32 - init_left;
                rm[idx] = idx;
                known[idx] = 1;
                init_left--;
                e1 = 0;
                e2 = 0;
            end else begin
                if (bus.rd_en) begin
                    e1 = rd_ref(bus.rd_addr_1);
                    e2 = rd_ref(bus.rd_addr_2);
                end
                if (bus.wr_en && bus.wr_addr != 0)
                    rm[bus.wr_addr] = merge(rm[bus.wr_addr], bus.wr_data,
                                            bus.wr_be);
            end
            ed = d;
            ed_ok = dk;
        end
        @(posedge clk);
        #1;
        check({tag, ".busy"}, {31'b0, bus.init_busy}, (init_left > 0) ? 1 : 0);
        check({tag, ".rd1"}, bus.rd_data_1, e1);
        check({tag, ".rd2"}, bus.rd_data_2, e2);
        if (ed_ok) check({tag, ".dbg"}, bus.dbg_data, ed);
    endtask

    task automatic idle();
        bus.rd_en = 0;
        bus.wr_en = 0;
        bus.wr_be = '0;
        bus.rd_addr_1 = '0;
        bus.rd_addr_2 = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.dbg_addr = '0;
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (bus.init_busy && n < 100) begin
            tick(tag);
            n++;
        end
        check({tag, ".len"}, n, 32);
    endtask

    // ---------------- reference model, small build ----------------
    logic [15:0] rs [8];
    int          left_s;
    logic [15:0] s1, s2, sd;
    bit          sd_ok;

    function automatic logic [15:0] rd_ref_s(input logic [2:0] a);
        logic [31:0] t;
        t = {16'h0, rs[a]};
        if (bus_s.wr_en && bus_s.wr_addr == a)
            t = merge(t, {16'h0, bus_s.wr_data}, {2'b0, bus_s.wr_be});
        return t[15:0];
    endfunction

    task automatic tick_s(input string tag);
        logic [15:0] d;
        if (!rst_n_s) begin
            left_s = 8;
            s1 = 0;
            s2 = 0;
            sd = 0;
            sd_ok = 1;
        end else begin
            sd_ok = (left_s == 0);
            d = rs[bus_s.dbg_addr];
            if (left_s > 0) begin
                rs[8 - left_s] = 16'h0;
                left_s--;
                s1 = 0;
                s2 = 0;
            end else begin
                if (bus_s.rd_en) begin
                    s1 = rd_ref_s(bus_s.rd_addr_1);
                    s2 = rd_ref_s(bus_s.rd_addr_2);
                end
                if (bus_s.wr_en)
                    rs[bus_s.wr_addr] = rd_ref_s(bus_s.wr_addr);
            end
            sd = d;
        end
        @(posedge clk);
        #1;
        check({tag, ".busy"}, {31'b0, bus_s.init_busy}, (left_s > 0) ? 1 : 0);
        check({tag, ".rd1"}, {16'h0, bus_s.rd_data_1}, {16'h0, s1});
        check({tag, ".rd2"}, {16'h0, bus_s.rd_data_2}, {16'h0, s2});
        if (sd_ok) check({tag, ".dbg"}, {16'h0, bus_s.dbg_data}, {16'h0, sd});
    endtask

    task automatic idle_s();
        bus_s.rd_en = 0;
        bus_s.wr_en = 0;
        bus_s.wr_be = '0;
        bus_s.rd_addr_1 = '0;
        bus_s.rd_addr_2 = '0;
        bus_s.wr_addr = '0;
        bus_s.wr_data = '0;
        bus_s.dbg_addr = '0;
    endtask

    initial begin
        int n;
        rst_n = 0;
        rst_n_s = 0;
        idle();
        idle_s();

        // reset and default init
        tick("rst");
        tick("rst");
        rst_n = 1;
        wait_init("init");

        // read init values
        bus.rd_en = 1;
        bus.rd_addr_1 = 5'd7;
        bus.rd_addr_2 = 5'd31;
        tick("rd_init");
        check("rd_init.a7", bus.rd_data_1, 32'd7);
        check("rd_init.a31", bus.rd_data_2, 32'd31);
        bus.rd_en = 0;
        tick("hold");

        // byte enables
        bus.wr_en = 1;
        bus.wr_addr = 5'd5;
        bus.wr_data = 32'hAABBCCDD;
        bus.wr_be = 4'b1111;
        tick("be1");
        bus.wr_data = 32'h11223344;
        bus.wr_be = 4'b0101;
        tick("be2");
        bus.wr_en = 0;
        bus.rd_en = 1;
        bus.rd_addr_1 = 5'd5;
        bus.rd_addr_2 = 5'd5;
        tick("be_rd");
        check("be_rd.val", bus.rd_data_1, 32'hAA22CC44);

        // bypass on same-cycle read/write, debug sees pre-write value
        bus.wr_en = 1;
        bus.wr_addr = 5'd9;
        bus.wr_data = 32'hDEADBEEF;
        bus.wr_be = 4'b0011;
        bus.rd_addr_1 = 5'd9;
        bus.rd_addr_2 = 5'd9;
        bus.dbg_addr = 5'd9;
        tick("byp");
        check("byp.rd1", bus.rd_data_1, 32'h0000BEEF);
        check("byp.dbg", bus.dbg_data, 32'h00000009);

        // zero entry, including bypass
        bus.wr_addr = 5'd0;
        bus.wr_data = 32'hFFFFFFFF;
        bus.wr_be = 4'b1111;
        bus.rd_addr_1 = 5'd0;
        bus.rd_addr_2 = 5'd0;
        bus.dbg_addr = 5'd0;
        tick("zero_w");
        bus.wr_en = 0;
        tick("zero_r");
        check("zero.rd1", bus.rd_data_1, 32'h0);
        check("zero.rd2", bus.rd_data_2, 32'h0);
        check("zero.dbg", bus.dbg_data, 32'h0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bus.rd_en = 1'($urandom_range(0, 1));
            bus.wr_en = 1'($urandom_range(0, 1));
            bus.rd_addr_1 = 5'($urandom);
            bus.rd_addr_2 = ($urandom_range(0, 3) == 0) ? bus.rd_addr_1
                                                         : 5'($urandom);
            bus.wr_addr = ($urandom_range(0, 2) == 0) ? bus.rd_addr_1
                                                       : 5'($urandom);
            bus.wr_data = $urandom;
            bus.wr_be = 4'($urandom);
            bus.dbg_addr = ($urandom_range(0, 3) == 0) ? bus.wr_addr
                                                        : 5'($urandom);
            tick("rnd");
        end

        // reset mid-run and mid-init
        idle();
        bus.wr_en = 1;
        bus.wr_addr = 5'd3;
        bus.wr_data = 32'h55;
        bus.wr_be = 4'hF;
        tick("mid_w3");
        rst_n = 0;
        bus.wr_addr = 5'd4;
        bus.wr_data = 32'h77;
        tick("mid_rst");
        rst_n = 1;
        bus.rd_en = 1;
        for (int i = 0; i < 10; i++) begin
            bus.wr_addr = 5'(3 + (i % 2));
            bus.wr_data = $urandom;
            bus.rd_addr_1 = 5'd3;
            bus.rd_addr_2 = 5'd4;
            tick("mid_init");
        end
        rst_n = 0;
        tick("mid_rst2");
        rst_n = 1;
        wait_init("reinit");
        bus.wr_en = 0;
        tick("reinit_rd");
        check("reinit.a3", bus.rd_data_1, 32'd3);
        check("reinit.a4", bus.rd_data_2, 32'd4);

        // small build: zero fill, writable entry 0
        idle();
        tick_s("s_rst");
        tick_s("s_rst");
        rst_n_s = 1;
        n = 0;
        while (bus_s.init_busy && n < 50) begin
            tick_s("s_init");
            n++;
        end
        check("s_init.len", n, 8);
        bus_s.rd_en = 1;
        for (int i = 0; i < 4; i++) begin
            bus_s.rd_addr_1 = 3'(2 * i);
            bus_s.rd_addr_2 = 3'(2 * i + 1);
            tick_s("s_clr");
            check("s_clr.rd1", {16'h0, bus_s.rd_data_1}, 32'h0);
            check("s_clr.rd2", {16'h0, bus_s.rd_data_2}, 32'h0);
        end
        bus_s.rd_en = 0;
        bus_s.wr_en = 1;
        bus_s.wr_addr = 3'd0;
        bus_s.wr_data = 16'hBEEF;
        bus_s.wr_be = 2'b11;
        tick_s("s_w0");
        bus_s.wr_en = 0;
        bus_s.rd_en = 1;
        bus_s.rd_addr_1 = 3'd0;
        tick_s("s_r0");
        check("s_r0.val", {16'h0, bus_s.rd_data_1}, 32'hBEEF);
        for (int i = 0; i < 200; i++) begin
            bus_s.rd_en = 1'($urandom_range(0, 1));
            bus_s.wr_en = 1'($urandom_range(0, 1));
            bus_s.rd_addr_1 = 3'($urandom);
            bus_s.rd_addr_2 = 3'($urandom);
            bus_s.wr_addr = ($urandom_range(0, 2) == 0) ? bus_s.rd_addr_2
                                                         : 3'($urandom);
            bus_s.wr_data = 16'($urandom);
            bus_s.wr_be = 2'($urandom);
            bus_s.dbg_addr = 3'($urandom);
            tick_s("s_rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_file_param.md
REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits; legal values are multiples of 8 and at least 8.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, entry 0 always reads 0 and ignores writes.
REQ-004 SHALL have parameter INIT_MODE, default 1; 0 = entries clear to 0, 1 = entry k clears to value k (zero-extended).
REQ-005 SHALL have port clock, input, 1, the only clock; all logic is rising-edge.
REQ-006 SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-007 SHALL have ports rd_addr_1 and rd_addr_2, input, ADDR_W, read addresses.
REQ-008 SHALL have port rd_en, input, 1, which samples both read ports.
REQ-009 SHALL have ports rd_data_1 and rd_data_2, output, DATA_W, registered read data.
REQ-010 SHALL have port wr_en, input, 1, write strobe.
REQ-011 SHALL have port wr_addr, input, ADDR_W, write address.
REQ-012 SHALL have port wr_data, input, DATA_W, write data.
REQ-013 SHALL have port wr_be, input, DATA_W/8, byte enables; bit b gates wr_data[8b+7:8b].
REQ-014 SHALL have port dbg_addr, input, ADDR_W, debug read address.
REQ-015 SHALL have port dbg_data, output, DATA_W, registered debug read data.
REQ-016 SHALL have port init_busy, output, 1, high while the init sequencer runs.

Function
REQ-017 SHALL implement a two-state FSM: INIT and RUN.
REQ-018 In INIT, SHALL write the INIT_MODE value to entry init_ptr each cycle, then increment init_ptr, which starts at 0.
REQ-019 SHALL go from INIT to RUN in the cycle that writes entry DEPTH-1; init_ptr SHALL NOT wrap or keep counting.
REQ-020 init_busy SHALL equal (state == INIT), so init lasts exactly DEPTH cycles after reset_n rises.
REQ-021 In INIT, SHALL ignore wr_en and rd_en and hold rd_data_1/rd_data_2 at 0; dbg_data keeps operating.
REQ-022 In RUN, when wr_en=1, SHALL update only the enabled bytes of entry wr_addr at the clock edge; wr_be=0 is a no-op.
REQ-023 In RUN, when rd_en=1, SHALL load rd_data_n with entry rd_addr_n at the edge; data is visible one cycle after rd_en.
REQ-024 In RUN, when rd_en=0, rd_data_1/rd_data_2 SHALL hold their values.
REQ-025 On a same-cycle read and write to the same address, read data SHALL bypass: enabled bytes from wr_data, other bytes from the stored entry.
REQ-026 With ZERO_REG=1, address 0 SHALL read 0 on all ports, including during bypass; writes to address 0 SHALL be discarded.
REQ-027 With ZERO_REG=1, the INIT write to entry 0 SHALL be irrelevant to any output.
REQ-028 SHALL load dbg_data with entry dbg_addr every cycle, with 1-cycle latency and no bypass (pre-write value).
REQ-029 Both read ports addressing the same entry SHALL return identical data.

Reset
REQ-030 While reset_n=0 at an edge, SHALL set state=INIT, init_ptr=0, rd_data_1=0, rd_data_2=0, dbg_data=0, and leave array contents unchanged.
REQ-031 Asserting reset_n mid-INIT or mid-RUN SHALL restart init from entry 0; a write presented in the reset cycle SHALL be dropped.
REQ-032 init_busy SHALL read 1 during reset and stay 1 for DEPTH cycles after release.

Verification
REQ-033 Reset then release, defaults: init_busy is high for exactly 32 cycles; then rd_en with rd_addr_1=7, rd_addr_2=31 -> rd_data 7 and 31 one cycle later.
REQ-034 Byte-enable write: write 0xAABBCCDD to addr 5 (be=1111), then 0x11223344 with be=0101 -> read addr 5 = 0xAA22CC44.
REQ-035 Bypass: same cycle as a write of 0xDEADBEEF (be=0011) to addr 9 (init value 9), rd_en with rd_addr_1=9 -> rd_data_1=0x0000BEEF; dbg_addr=9 -> dbg_data=0x00000009.
REQ-036 Zero register: write 0xFFFFFFFF to addr 0 -> rd_data_1, rd_data_2 and dbg_data read 0 at addr 0.
REQ-037 Reset mid-operation: write 0x55 to addr 3, pulse reset_n low 1 cycle during a write to addr 4 -> after re-init, addr 3 = 3 and addr 4 = 4; no writes are accepted until init_busy falls.
REQ-038 Parameter sweep DATA_W=16, ADDR_W=3, INIT_MODE=0, ZERO_REG=0 -> init lasts 8 cycles, all entries read 0, and addr 0 is writable.
